// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and default timing for button_bank.
// Holds RELEASED/HELD/REPEATING and the default debounce/repeat cycle counts.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HELD      = 2'd1,
        REPEATING = 2'd2
    } btn_state_t;

    localparam int DEF_DB_CYCLES     = 500000;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_PERIOD = 5000000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_chan.sv
// button_chan: one button channel -- 2-flop synchronizer, debounce counter,
// press/release pulses and the RELEASED/HELD/REPEATING state machine.
// Ports: clk, rst (async, active-low), btn (raw input), level (debounced),
//        press (pulse per accepted press or repeat), rel (release pulse).
// Auto-repeat is built only when BUTTON_BANK_REPEAT_EN is defined.
module button_chan
    import button_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_chan: illegal timing parameters");
    end

    logic          s1;
    logic          sync;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          level_n;
    logic          press_n;
    logic          rel_n;
    logic          flip;
    btn_state_t    state;
    btn_state_t    state_n;

    // Input has disagreed with level for DB_CYCLES cycles: accept it.
    assign flip = (sync != level) && (cnt == DB_LAST);

`ifdef BUTTON_BANK_REPEAT_EN
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_n;
    logic [RW-1:0] rlast;

    // First repeat waits the long delay, later ones the short period.
    assign rlast = (state == HELD) ? RD_LAST : RP_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt_n;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            state <= RELEASED;
        end else begin
            s1    <= btn;
            sync  <= s1;
            cnt   <= cnt_n;
            level <= level_n;
            press <= press_n;
            rel   <= rel_n;
            state <= state_n;
        end
    end

    always_comb begin
        cnt_n   = cnt;
        level_n = level;
        press_n = 1'b0;
        rel_n   = 1'b0;
        state_n = state;
`ifdef BUTTON_BANK_REPEAT_EN
        rcnt_n  = rcnt;
`endif

        if (sync == level) begin
            cnt_n = '0;
        end else if (flip) begin
            cnt_n   = '0;
            level_n = ~level;
        end else begin
            cnt_n = cnt + 1'b1;
        end

        // Pulses are registered with the level toggle so they line up
        // with the first cycle the new level is visible.
        unique case (state)
            RELEASED: begin
                if (flip) begin
                    state_n = HELD;
                    press_n = 1'b1;
`ifdef BUTTON_BANK_REPEAT_EN
                    rcnt_n  = '0;
`endif
                end
            end
            HELD, REPEATING: begin
                if (flip) begin
                    state_n = RELEASED;
                    rel_n   = 1'b1;
                end
`ifdef BUTTON_BANK_REPEAT_EN
                else if (rcnt == rlast) begin
                    state_n = REPEATING;
                    press_n = 1'b1;
                    rcnt_n  = '0;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
`endif
            end
            default: begin
                state_n = RELEASED;
            end
        endcase
    end

endmodule

// File: rtl/button_bank.sv
// button_bank: N_BTN independent debounced button channels.
// Ports: clk, rst (async, active-low), btn[N_BTN] raw inputs,
//        level/press/rel[N_BTN] debounced level, press and release pulses.
// Define BUTTON_BANK_REPEAT_EN to enable held-button auto-repeat presses.
module button_bank
    import button_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] rel
);

    if (N_BTN < 1 || N_BTN > 32) begin : g_bad_width
        $error("button_bank: N_BTN out of range");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_chan #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .level(level[i]),
            .press(press[i]),
            .rel  (rel[i])
        );
    end

endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: random and directed stimulus for button_bank,
// compared cycle by cycle against a sample-window reference model.
module tb_button_bank;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef BUTTON_BANK_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;

    int nvec = 0;
    int nerr = 0;

    // Reference model: raw samples since reset, model outputs, held age.
    bit           hist[N][$];
    logic [N-1:0] m_lvl;
    logic [N-1:0] m_prs;
    logic [N-1:0] m_rel;
    int           age[N];
    int           pcnt[N];
    int           rcnt[N];

    button_bank #(
        .N_BTN        (N),
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .level(level),
        .press(press),
        .rel  (rel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            hist[c].delete();
            age[c] = 0;
        end
        m_lvl = '0;
        m_prs = '0;
        m_rel = '0;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < N; c++) begin
            pcnt[c] = 0;
            rcnt[c] = 0;
        end
    endtask

    // A level is accepted once the last DB synchronized samples (raw
    // samples delayed by two edges; zero before reset ended) all differ.
    task automatic model_step(input logic [N-1:0] v);
        for (int c = 0; c < N; c++) begin
            int n;
            bit all_diff;
            hist[c].push_back(v[c]);
            n = hist[c].size() - 1;
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++) begin
                int idx;
                bit s;
                idx = n - 2 - k;
                s = (idx < 0) ? 1'b0 : hist[c][idx];
                if (s == m_lvl[c]) all_diff = 1'b0;
            end
            m_prs[c] = 1'b0;
            m_rel[c] = 1'b0;
            if (all_diff) begin
                m_lvl[c] = ~m_lvl[c];
                if (m_lvl[c]) begin
                    age[c]   = 0;
                    m_prs[c] = 1'b1;
                end else begin
                    m_rel[c] = 1'b1;
                end
            end else if (m_lvl[c]) begin
                age[c]++;
                if (REP && age[c] >= RD && ((age[c] - RD) % RP) == 0)
                    m_prs[c] = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic [N-1:0] v);
        btn = v;
        @(posedge clk);
        model_step(v);
        #1;
        chk("level", 32'(level), 32'(m_lvl));
        chk("press", 32'(press), 32'(m_prs));
        chk("release", 32'(rel), 32'(m_rel));
        chk("excl", 32'(press & rel), 32'd0);
        for (int c = 0; c < N; c++) begin
            pcnt[c] += int'(press[c]);
            rcnt[c] += int'(rel[c]);
        end
    endtask

    task automatic wait_level(input int c, input logic want, output int t);
        t = -1;
        for (int i = 1; i <= 30; i++) begin
            tick(btn);
            if (level[c] == want) begin
                t = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_press", 32'(press), 32'd0);
        chk("rst_release", 32'(rel), 32'd0);
        model_clear();
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int t;
        int hold[N];
        logic [N-1:0] v;

        rst = 1'b0;
        btn = '0;
        model_clear();
        clear_counts();
        #12;
        chk("init_level", 32'(level), 32'd0);
        chk("init_press", 32'(press), 32'd0);
        chk("init_release", 32'(rel), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Clean press on channel 0.
        clear_counts();
        btn = 4'b0001;
        wait_level(0, 1'b1, t);
        chk("lat_rise0", t, 6);
        for (int i = 0; i < 9; i++) tick(4'b0001);
        chk("press_cnt0", pcnt[0], 1);
        chk("others_idle", 32'(level[3:1]), 32'd0);
        btn = 4'b0000;
        wait_level(0, 1'b0, t);
        chk("lat_fall0", t, 6);
        for (int i = 0; i < 5; i++) tick(4'b0000);

        // Short glitch on channel 1 is filtered.
        clear_counts();
        for (int i = 0; i < 3; i++) tick(4'b0010);
        for (int i = 0; i < 12; i++) tick(4'b0000);
        chk("glitch_press1", pcnt[1], 0);
        chk("glitch_release1", rcnt[1], 0);

        // Hold channel 2 for 20 cycles, then release.
        clear_counts();
        for (int i = 0; i < 20; i++) tick(4'b0100);
        btn = 4'b0000;
        wait_level(2, 1'b0, t);
        chk("lat_fall2", t, 6);
        for (int i = 0; i < 5; i++) tick(4'b0000);
        chk("press_cnt2", pcnt[2], REP ? 5 : 1);
        chk("release_cnt2", rcnt[2], 1);

        // Long hold on channel 3; nothing after the release.
        clear_counts();
        for (int i = 0; i < 40; i++) tick(4'b1000);
        for (int i = 0; i < 16; i++) tick(4'b0000);
        chk("press_cnt3", pcnt[3], REP ? 11 : 1);
        chk("release_cnt3", rcnt[3], 1);

        // Reset mid-debounce on channel 0.
        for (int i = 0; i < 4; i++) tick(4'b0001);
        clear_counts();
        do_reset();
        wait_level(0, 1'b1, t);
        chk("lat_rst0", t, 6);
        for (int i = 0; i < 8; i++) tick(4'b0001);
        chk("press_rst0", pcnt[0], 1);
        for (int i = 0; i < 12; i++) tick(4'b0000);

        // Reset while channel 3 is held (repeating if enabled).
        for (int i = 0; i < 20; i++) tick(4'b1000);
        clear_counts();
        do_reset();
        wait_level(3, 1'b1, t);
        chk("lat_rst3", t, 6);
        for (int i = 0; i < 12; i++) tick(4'b0000);
        chk("press_rst3", pcnt[3], 1);

        // All channels toggling with independent random hold lengths.
        v = '0;
        for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 14);
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < N; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    v[c] = ~v[c];
                    hold[c] = $urandom_range(1, 14);
                end
            end
            tick(v);
        end
        for (int i = 0; i < 20; i++) tick(4'b0000);
        chk("final_level", 32'(level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/button_bank.md
BUTTON_BANK -- requirements
Module: button_bank

Interface
REQ-001 Parameter N_BTN, default 4: number of independent button channels, legal range 1..32.
REQ-002 Parameter DB_CYCLES, default 500000: consecutive stable cycles required to accept a new level, minimum 2.
REQ-003 Parameter REPEAT_DELAY, default 25000000: held cycles before the first auto-repeat pulse; used only with BUTTON_BANK_REPEAT_EN.
REQ-004 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses; used only with BUTTON_BANK_REPEAT_EN.
REQ-005 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn  in  N_BTN  raw asynchronous button inputs, 1 = pressed.
- level  out  N_BTN  debounced button state.
- press  out  N_BTN  single-cycle pulse per accepted press (and per repeat, if enabled).
- release  out  N_BTN  single-cycle pulse per accepted release.

Function
REQ-006 Each channel i shall be processed independently; no output of channel i shall depend on btn[j], j≠i.
REQ-007 btn[i] shall pass through a 2-flop synchronizer; only the second flop (sync) feeds the debounce logic.
REQ-008 The debounce counter (width clog2(DB_CYCLES)) shall increment each cycle sync≠level[i], and clear to 0 whenever sync==level[i].
REQ-009 On the cycle where the counter equals DB_CYCLES-1 and sync≠level[i], level[i] shall toggle and the counter shall clear.
REQ-010 For a clean step on btn[i], level[i] shall change exactly 2+DB_CYCLES rising edges after the first edge sampling the new value.
REQ-011 A btn[i] glitch lasting fewer than DB_CYCLES synchronized cycles shall leave level[i], press[i] and release[i] unchanged.
REQ-012 press[i] shall be high for exactly the one cycle in which level[i] first reads 1 after a 0→1 toggle, and release[i] for the one cycle in which level[i] first reads 0 after a 1→0 toggle.
REQ-013 press[i] and release[i] shall never both be high in the same cycle.
REQ-014 All outputs shall be driven directly from flops, with no combinational path from btn to any output.
REQ-015 Per-channel state machine: RELEASED (level 0), HELD (level 1, waiting REPEAT_DELAY), REPEATING (level 1, pulsing every REPEAT_PERIOD); accepting a release from any state shall return to RELEASED.

Reset
REQ-016 While rst=0, all synchronizer flops, counters, level, press and release shall be 0 and every channel shall be in RELEASED, asynchronously.
REQ-017 Reset asserted mid-debounce or mid-repeat shall discard all progress; after deassertion a held button shall be re-accepted with full REQ-010 latency, producing one press pulse.

Configuration
REQ-018 Macro BUTTON_BANK_REPEAT_EN: when defined, HELD→REPEATING occurs after REPEAT_DELAY cycles of level[i]=1 with a press pulse, and further press pulses occur every REPEAT_PERIOD cycles while level[i]=1.
REQ-019 Without BUTTON_BANK_REPEAT_EN, HELD is terminal until release, exactly one press pulse is issued per accepted press, and no repeat counter is synthesized.

Structure
REQ-020 Package button_pkg shall hold the state encoding (RELEASED, HELD, REPEATING) and the default values of DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
REQ-021 Sub-module button_chan shall implement one channel (synchronizer, debounce, edge pulses, repeat FSM); button_bank shall instantiate it N_BTN times in a generate loop.

Verification (bench: N_BTN=4, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-022 Step btn[0] 0→1 and hold -> level[0] rises 6 edges later, press[0] high exactly 1 cycle, other channels stay 0.
REQ-023 Pulse btn[1] high for 3 cycles, then low -> level[1], press[1] and release[1] stay 0.
REQ-024 Hold btn[2] for 20 debounced cycles, then release -> one press, one release 6 edges after the falling step; without the macro, no extra press.
REQ-025 With BUTTON_BANK_REPEAT_EN, hold btn[3] -> press at acceptance, again 10 cycles later, then every 3 cycles until release; none after release accepted.
REQ-026 Assert rst=0 for 1 cycle at debounce count 2 while btn[0]=1 -> all outputs 0 immediately; press[0] fires 6 edges after rst=1.
REQ-027 Toggle btn[0..3] simultaneously with different hold lengths -> each channel matches its single-channel response independently.
